// File: rtl/sweep_ctrl.sv
// sweep_ctrl: linear ramp of the phase-accumulator increment m from a start to a stop value.
// Optional loop mode: `SWEEP_LOOP_EN makes the sweep restart at the start value instead of finishing.
// Timing: m_out/busy follow an accepted start after one edge, each value is held max(dwell,1) cycles, abort takes one edge.
module sweep_ctrl #(
    parameter int W  = 11,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  cfg_start,
    input  logic [W-1:0]  cfg_stop,
    input  logic [W-1:0]  cfg_step,
    input  logic [DW-1:0] cfg_dwell,
    output logic [W-1:0]  m_out,
    output logic          busy,
    output logic          done,
    output logic          aborted
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DWELL = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state_q;
    logic [DW-1:0] cnt_q;

    // Shadow copies of the configuration, frozen for the duration of a sweep.
`ifdef SWEEP_LOOP_EN
    logic [W-1:0]  sh_start;
`endif
    logic [W-1:0]  sh_stop;
    logic [W-1:0]  sh_step;
    logic [DW-1:0] sh_dwell;

    logic          start_acc;
    logic [DW-1:0] cfg_reload;
    logic [DW-1:0] sh_reload;
    logic [W:0]    nxt;
    logic          end_of_sweep;

    // A start is only honoured in IDLE and only when abort is not also asserted.
    assign start_acc = (state_q == S_IDLE) && start && !abort;

    // A dwell of 0 behaves as 1, so the counter reload saturates at 0.
    assign cfg_reload = (cfg_dwell == '0) ? '0 : cfg_dwell - DW'(1);
    assign sh_reload  = (sh_dwell  == '0) ? '0 : sh_dwell  - DW'(1);

    // One extra bit keeps the compare honest near the top of the range: no wrap.
    assign nxt          = {1'b0, m_out} + {1'b0, sh_step};
    assign end_of_sweep = (sh_step == '0) || (nxt > {1'b0, sh_stop});

    // Capture the configuration when a sweep is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef SWEEP_LOOP_EN
            sh_start <= '0;
`endif
            sh_stop  <= '0;
            sh_step  <= '0;
            sh_dwell <= '0;
        end else if (start_acc) begin
`ifdef SWEEP_LOOP_EN
            sh_start <= cfg_start;
`endif
            sh_stop  <= cfg_stop;
            sh_step  <= cfg_step;
            sh_dwell <= cfg_dwell;
        end
    end

    // Sweep state machine; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            m_out   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_acc) begin
                        state_q <= S_DWELL;
                        m_out   <= cfg_start;
                        cnt_q   <= cfg_reload;
                        busy    <= 1'b1;
                    end
                end
                S_DWELL: begin
                    if (abort) begin
                        // Abort takes priority over an end of hold in the same cycle.
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        m_out   <= '0;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DW'(1);
                    end else if (end_of_sweep) begin
`ifdef SWEEP_LOOP_EN
                        m_out <= sh_start;
                        cnt_q <= sh_reload;
`else
                        state_q <= S_DONE;
                        m_out   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
`endif
                    end else begin
                        m_out <= nxt[W-1:0];
                        cnt_q <= sh_reload;
                    end
                end
                S_DONE: begin
                    // Single-cycle completion state; start is not queued here.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    m_out   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Testbench for sweep_ctrl: per-cycle expected outputs are queued when stimulus is applied,
// then popped and compared one cycle at a time, sampling 1 time unit after the rising edge.
module tb_sweep_ctrl;

    localparam int W  = 11;
    localparam int DW = 16;

    typedef struct packed {
        logic [W-1:0] m;
        logic         busy;
        logic         done;
        logic         aborted;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  cfg_start = '0;
    logic [W-1:0]  cfg_stop = '0;
    logic [W-1:0]  cfg_step = '0;
    logic [DW-1:0] cfg_dwell = '0;
    logic [W-1:0]  m_out;
    logic          busy;
    logic          done;
    logic          aborted;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    sweep_ctrl #(.W(W), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cfg_start (cfg_start),
        .cfg_stop  (cfg_stop),
        .cfg_step  (cfg_step),
        .cfg_dwell (cfg_dwell),
        .m_out     (m_out),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int m, input logic b, input logic d, input logic a);
        exp_t e;
        e.m       = W'(m);
        e.busy    = b;
        e.done    = d;
        e.aborted = a;
        return e;
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("m=%0d busy=%0b done=%0b aborted=%0b", e.m, e.busy, e.done, e.aborted);
    endfunction

    function automatic exp_t observed();
        exp_t e;
        e.m       = m_out;
        e.busy    = busy;
        e.done    = done;
        e.aborted = aborted;
        return e;
    endfunction

    // Reference model of a single-shot sweep: values, done pulse, one idle cycle.
    function automatic void push_sweep(input int s, input int stop, input int step, input int dwell);
        int d = (dwell == 0) ? 1 : dwell;
        int v = s;
        forever begin
            for (int i = 0; i < d; i++) exp_q.push_back(mk(v, 1'b1, 1'b0, 1'b0));
            if (step == 0 || v + step > stop) break;
            v = v + step;
        end
        exp_q.push_back(mk(0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
    endfunction

    task automatic set_cfg(input int s, input int stop, input int step, input int dwell);
        cfg_start = W'(s);
        cfg_stop  = W'(stop);
        cfg_step  = W'(step);
        cfg_dwell = DW'(dwell);
    endtask

    task automatic test_reset();
        exp_t e, g;
        int c = 0;
        rst = 1'b1;
        start = 1'b1;
        set_cfg(100, 130, 10, 3);
        repeat (3) exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; c++;
            e = exp_q.pop_front();
            g = observed();
            vectors++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset c%0d got %s want %s", c, fmt(g), fmt(e));
            end
            if (c == 2) begin rst = 1'b0; start = 1'b0; end
        end
    endtask

    task automatic run_sweep(input string name, input int s, input int stop, input int step, input int dwell);
        exp_t e, g;
        int c = 0;
        set_cfg(s, stop, step, dwell);
        push_sweep(s, stop, step, dwell);
        start = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; c++;
            start = 1'b0;
            e = exp_q.pop_front();
            g = observed();
            vectors++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s c%0d got %s want %s", name, c, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_normal_sweep();
        run_sweep("normal", 100, 130, 10, 3);
    endtask

    task automatic test_top_of_range();
        run_sweep("top_range", 2045, 2047, 10, 0);
    endtask

    task automatic test_degenerate();
        run_sweep("step_zero", 100, 130, 0, 3);
        run_sweep("start_gt_stop", 200, 100, 5, 2);
    endtask

    task automatic test_abort();
        exp_t e, g;
        int c = 0;
        set_cfg(100, 130, 10, 3);
        repeat (3) exp_q.push_back(mk(100, 1'b1, 1'b0, 1'b0));
        repeat (2) exp_q.push_back(mk(110, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b1));
        repeat (3) exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
        start = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; c++;
            start = 1'b0;
            e = exp_q.pop_front();
            g = observed();
            vectors++;
            if (g !== e) begin
                errors++;
                $display("FAIL abort c%0d got %s want %s", c, fmt(g), fmt(e));
            end
            abort = (c == 5);
        end
        // start together with abort in IDLE must not launch a sweep
        repeat (2) exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
        start = 1'b1;
        abort = 1'b1;
        c = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; c++;
            e = exp_q.pop_front();
            g = observed();
            vectors++;
            if (g !== e) begin
                errors++;
                $display("FAIL start_abort c%0d got %s want %s", c, fmt(g), fmt(e));
            end
            if (c == 1) begin start = 1'b0; abort = 1'b0; end
        end
    endtask

    task automatic test_start_ignored();
        exp_t e, g;
        int c = 0;
        set_cfg(100, 130, 10, 3);
        push_sweep(100, 130, 10, 3);
        start = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; c++;
            e = exp_q.pop_front();
            g = observed();
            vectors++;
            if (g !== e) begin
                errors++;
                $display("FAIL start_ignored c%0d got %s want %s", c, fmt(g), fmt(e));
            end
            if (c == 1) start = 1'b0;
            if (c == 2) begin
                start = 1'b1;
                set_cfg(0, 2047, 1, 5);
            end
            if (c == 13) start = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, g;
        int c = 0;
        set_cfg(100, 130, 10, 3);
        repeat (3) exp_q.push_back(mk(100, 1'b1, 1'b0, 1'b0));
        repeat (3) exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
        start = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; c++;
            start = 1'b0;
            e = exp_q.pop_front();
            g = observed();
            vectors++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_mid c%0d got %s want %s", c, fmt(g), fmt(e));
            end
            rst = (c == 3);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, g;
        int c = 0;
        set_cfg(5, 6, 1, 1);
        push_sweep(5, 6, 1, 1);
        push_sweep(5, 6, 1, 1);
        start = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; c++;
            e = exp_q.pop_front();
            g = observed();
            vectors++;
            if (g !== e) begin
                errors++;
                $display("FAIL back_to_back c%0d got %s want %s", c, fmt(g), fmt(e));
            end
            if (c == 6) start = 1'b0;
        end
    endtask

`ifdef SWEEP_LOOP_EN
    task automatic test_loop();
        exp_t e, g;
        int c = 0;
        int seq[7] = '{0, 2, 4, 0, 2, 4, 0};
        set_cfg(0, 4, 2, 1);
        foreach (seq[i]) exp_q.push_back(mk(seq[i], 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
        start = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; c++;
            start = 1'b0;
            e = exp_q.pop_front();
            g = observed();
            vectors++;
            if (g !== e) begin
                errors++;
                $display("FAIL loop c%0d got %s want %s", c, fmt(g), fmt(e));
            end
            abort = (c == 7);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SWEEP_LOOP_EN
        test_loop();
`else
        test_normal_sweep();
        test_top_of_range();
        test_abort();
        test_start_ignored();
        test_degenerate();
        test_reset_mid();
        test_back_to_back();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
